// File: rtl/cbd_ctrl.sv
// cbd_ctrl: Kyber noise-sampling sequencer (PRF -> FIFO -> cbd -> poly RAM); optional checker under CBD_CTRL_ERRCHK_EN
module cbd_ctrl #(
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_POLY   = 4,
    parameter int ADDR_W     = 6
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [1:0]        i_eta,
    input  logic [2:0]        i_num_poly,
    input  logic [7:0]        i_nonce_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_prf_req,
    output logic [7:0]        o_prf_nonce,
    input  logic [63:0]       i_prf_data,
    input  logic              i_prf_valid,
    output logic              o_prf_ready,
    output logic [63:0]       o_cbd_ibytes,
    output logic              o_cbd_ibytes_valid,
    output logic [1:0]        o_cbd_eta,
    input  logic              i_cbd_ready,
    input  logic [47:0]       i_cbd_coeffs,
    input  logic              i_cbd_coeffs_valid,
    input  logic              i_cbd_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [47:0]       o_mem_wdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, FILL, STREAM, WAIT_DONE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [1:0]        eta_q, eta_d;
    logic [2:0]        num_q, num_d;
    logic [7:0]        base_q, base_d;
    logic [2:0]        poly_q, poly_d;
    logic [4:0]        pcnt_q, pcnt_d;
    logic [2:0]        req_cnt_q;
    logic [5:0]        outst_q;
    logic [63:0]       fifo_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic [4:0]        wcnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [47:0]       mem_wdata_q;
    logic [4:0]        wpp;
    logic              push, pop, start_acc, done_acc;

    assign wpp                = (eta_q == 2'd3) ? 5'd24 : 5'd16;
    assign o_busy             = state_q inside {FILL, STREAM, WAIT_DONE};
    assign o_done             = state_q == FINISH;
    assign o_cbd_ibytes_valid = state_q == STREAM;
    assign o_cbd_ibytes       = o_cbd_ibytes_valid ? fifo_q[rd_ptr_q] : '0;
    assign o_cbd_eta          = eta_q;
    assign o_prf_ready        = o_busy && cnt_q != CW'(FIFO_DEPTH);
    assign push               = i_prf_valid && o_prf_ready;
    assign pop                = o_cbd_ibytes_valid && i_cbd_ready;
    assign start_acc          = state_q == IDLE && i_start;
    assign done_acc           = state_q == WAIT_DONE && i_cbd_done;
    assign o_prf_req          = o_busy && req_cnt_q < num_q && outst_q == 6'd0 &&
                                (CW'(FIFO_DEPTH) - cnt_q) >= CW'(wpp);
    assign o_prf_nonce        = o_prf_req ? base_q + 8'(req_cnt_q) : '0;
    assign o_mem_we           = mem_we_q;
    assign o_mem_addr         = mem_addr_q;
    assign o_mem_wdata        = mem_wdata_q;

    // Command sequencing: latch the command, wait for a full polynomial in the FIFO, stream it, await cbd.
    always_comb begin
        state_d = state_q;
        eta_d   = eta_q;
        num_d   = num_q;
        base_d  = base_q;
        poly_d  = poly_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = FILL;
                eta_d   = (i_eta == 2'd3) ? 2'd3 : 2'd2;
                num_d   = (i_num_poly == 3'd0) ? 3'd1 :
                          (int'(i_num_poly) > MAX_POLY) ? 3'(MAX_POLY) : i_num_poly;
                base_d  = i_nonce_base;
                poly_d  = '0;
                pcnt_d  = '0;
            end
            FILL: if (cnt_q >= CW'(wpp)) state_d = STREAM;
            STREAM: if (pop) begin
                pcnt_d = (pcnt_q == wpp - 5'd1) ? 5'd0 : pcnt_q + 5'd1;
                if (pcnt_q == wpp - 5'd1) state_d = WAIT_DONE;
            end
            WAIT_DONE: if (i_cbd_done) begin
                state_d = (poly_q == num_q - 3'd1) ? FINISH : FILL;
                poly_d  = (poly_q == num_q - 3'd1) ? poly_q : poly_q + 3'd1;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request bookkeeping, FIFO pointers and RAM write port; everything aborts on reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            eta_q       <= '0;
            num_q       <= '0;
            base_q      <= '0;
            poly_q      <= '0;
            pcnt_q      <= '0;
            req_cnt_q   <= '0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            eta_q       <= eta_d;
            num_q       <= num_d;
            base_q      <= base_d;
            poly_q      <= poly_d;
            pcnt_q      <= pcnt_d;
            req_cnt_q   <= start_acc ? 3'd0 : req_cnt_q + 3'(o_prf_req);
            outst_q     <= start_acc ? 6'd0 : outst_q + (o_prf_req ? 6'(wpp) : 6'd0) -
                           6'(push && outst_q != 6'd0);
            wr_ptr_q    <= !push ? wr_ptr_q : (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            rd_ptr_q    <= !pop ? rd_ptr_q : (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            cnt_q       <= cnt_q + CW'(push) - CW'(pop);
            wcnt_q      <= (start_acc || done_acc) ? 5'd0 : wcnt_q + 5'(i_cbd_coeffs_valid);
            mem_we_q    <= i_cbd_coeffs_valid;
            mem_addr_q  <= i_cbd_coeffs_valid ? ADDR_W'({poly_q, 4'h0}) + ADDR_W'(wcnt_q[3:0]) : mem_addr_q;
            mem_wdata_q <= i_cbd_coeffs_valid ? i_cbd_coeffs : mem_wdata_q;
        end
    end

    // FIFO storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push) fifo_q[wr_ptr_q] <= i_prf_data;
    end

`ifdef CBD_CTRL_ERRCHK_EN
    logic [7:0] err_cnt_q;
    logic       err_ev;

    assign err_ev = (done_acc && wcnt_q != 5'd16) ||
                    (i_cbd_coeffs_valid && !(state_q inside {STREAM, WAIT_DONE})) ||
                    (push && outst_q == 6'd0);
    assign o_err  = err_cnt_q != 8'd0;

    // Saturating protocol-error count; nonzero doubles as the sticky error flag until the next command.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) err_cnt_q <= '0;
        else if (start_acc) err_cnt_q <= '0;
        else if (err_ev && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_cbd_ctrl.sv
// tb_cbd_ctrl: directed self-checking bench for cbd_ctrl with PRF and cbd behavioural models
module tb_cbd_ctrl;
    localparam int DEPTH = 32;
`ifdef CBD_CTRL_ERRCHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_eta = '0;
    logic [2:0]  i_num_poly = '0;
    logic [7:0]  i_nonce_base = '0;
    logic        o_busy, o_done, o_err, o_prf_req, o_prf_ready, o_cbd_ibytes_valid, o_mem_we;
    logic [7:0]  o_prf_nonce;
    logic [63:0] i_prf_data, o_cbd_ibytes;
    logic        i_prf_valid, i_cbd_ready, i_cbd_coeffs_valid, i_cbd_done;
    logic [1:0]  o_cbd_eta;
    logic [47:0] i_cbd_coeffs, o_mem_wdata;
    logic [5:0]  o_mem_addr;

    cbd_ctrl dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_eta(i_eta),
        .i_num_poly(i_num_poly), .i_nonce_base(i_nonce_base),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_prf_req(o_prf_req), .o_prf_nonce(o_prf_nonce),
        .i_prf_data(i_prf_data), .i_prf_valid(i_prf_valid), .o_prf_ready(o_prf_ready),
        .o_cbd_ibytes(o_cbd_ibytes), .o_cbd_ibytes_valid(o_cbd_ibytes_valid),
        .o_cbd_eta(o_cbd_eta), .i_cbd_ready(i_cbd_ready),
        .i_cbd_coeffs(i_cbd_coeffs), .i_cbd_coeffs_valid(i_cbd_coeffs_valid),
        .i_cbd_done(i_cbd_done),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0, n_err = 0;
    int cyc = 0, wpp = 16, num = 1, ncoef = 16, stall_until = 0;
    logic [7:0] base = '0;
    bit thr = 0, tmo = 0, saw_full = 0;
    int req_seen, pend, widx, mcnt, pop_poly, pop_idx, pops, coef_left, coef_n, done_seen, wr_idx;
    bit done_pend, done_prev, cv_prev;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic mdl_clear();
        req_seen = 0; pend = 0; widx = 0; mcnt = 0; pop_poly = 0; pop_idx = 0; pops = 0;
        coef_left = 0; coef_n = 0; done_seen = 0; wr_idx = 0;
        done_pend = 0; done_prev = 0; cv_prev = 0; stall_until = 0;
    endtask

    // PRF source, cbd sink and RAM-write monitor, all evaluated on the falling edge.
    initial begin
        bit push, pop, req;
        i_prf_valid = 0; i_prf_data = '0; i_cbd_ready = 0;
        i_cbd_coeffs = '0; i_cbd_coeffs_valid = 0; i_cbd_done = 0;
        mdl_clear();
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rstn) begin
                mdl_clear();
                i_prf_valid = 0; i_cbd_ready = 0; i_cbd_coeffs_valid = 0; i_cbd_done = 0;
            end else begin
                if (cv_prev || o_mem_we) begin
                    check("mem_we", o_mem_we, cv_prev);
                    check("mem_addr", o_mem_addr, wr_idx);
                    check("mem_wdata", o_mem_wdata, {16'hC0DE, 32'(wr_idx)});
                    wr_idx++;
                end
                if (done_prev || o_done) begin
                    check("done_pulse", o_done, done_prev && done_seen == num);
                    if (o_done) check("done_busy", o_busy, 0);
                end
                cv_prev = 0; i_cbd_done = 0; i_cbd_coeffs_valid = 0;
                if (coef_left > 0) begin
                    i_cbd_coeffs_valid = 1; i_cbd_coeffs = {16'hC0DE, 32'(coef_n)};
                    coef_n++; coef_left--; cv_prev = 1;
                end else if (done_pend) begin
                    i_cbd_done = 1; done_pend = 0; done_seen++;
                end
                done_prev = i_cbd_done;
                i_cbd_ready = cyc >= stall_until;
                if (o_cbd_ibytes_valid && pop_idx == 0) check("fill_level", mcnt >= wpp, 1);
                if (pop_idx > 0) check("stream_gap", o_cbd_ibytes_valid, 1);
                pop = o_cbd_ibytes_valid && i_cbd_ready;
                if (pop) begin
                    check("cbd_word", o_cbd_ibytes, {8'(base + 8'(pop_poly)), 48'h0, 8'(pop_idx)});
                    pop_idx++; pops++;
                    if (pop_idx == wpp) begin
                        pop_idx = 0; pop_poly++; coef_left = ncoef; done_pend = 1;
                    end
                end
                if (o_busy) begin
                    check("prf_ready", o_prf_ready, mcnt < DEPTH);
                    if (!o_prf_ready) saw_full = 1;
                end
                req = o_prf_req;
                if (req) begin
                    check("req_gap", pend, 0);
                    check("req_free", DEPTH - mcnt >= wpp, 1);
                    check("nonce", o_prf_nonce, 8'(base + 8'(req_seen)));
                end
                push = 0;
                if (pend > 0 && (!thr || cyc % 3 == 0)) begin
                    i_prf_valid = 1;
                    i_prf_data = {8'(base + 8'(req_seen - 1)), 48'h0, 8'(widx)};
                    push = o_prf_ready;
                    if (push) begin pend--; widx++; end
                end else i_prf_valid = 0;
                if (req) begin pend = wpp; widx = 0; req_seen++; end
                mcnt = mcnt + int'(push) - int'(pop);
            end
        end
    end

    task automatic launch(input logic [1:0] eta, input logic [2:0] np, input int nexp,
                          input logic [7:0] b, input bit t, input int stall, input int nc);
        mdl_clear();
        wpp = (eta == 2'd3) ? 24 : 16; num = nexp; base = b; thr = t; ncoef = nc; saw_full = 0;
        stall_until = cyc + stall;
        i_eta = eta; i_num_poly = np; i_nonce_base = b; i_start = 1;
        @(negedge i_clk);
        i_start = 0; i_eta = 2'd2; i_num_poly = 3'd1; i_nonce_base = 8'h77;
        check("busy_start", o_busy, 1);
        check("cbd_eta", o_cbd_eta, (eta == 2'd3) ? 2'd3 : 2'd2);
    endtask

    task automatic wait_done(input bit poke);
        int n;
        n = 0;
        while (!o_done && n < 4000) begin
            @(negedge i_clk);
            n++;
            i_start = poke && n == 40;
        end
        i_start = 0;
        tmo = n >= 4000;
    endtask

    task automatic post(input int nexp, input int nc, input logic ee);
        check("timeout", tmo, 0);
        check("req_count", req_seen, nexp);
        check("pop_count", pops, nexp * wpp);
        check("wr_count", wr_idx, nexp * nc);
        check("err_flag", o_err, ee);
        @(negedge i_clk);
        check("idle_busy", o_busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge i_clk);
        check("rst_outs", {o_busy, o_done, o_err, o_prf_req, o_prf_ready, o_cbd_ibytes_valid, o_mem_we, o_cbd_eta}, 0);
        check("rst_data", {o_prf_nonce, o_mem_addr, o_mem_wdata}, 0);
        i_rstn = 1;
        @(negedge i_clk);
        check("idle_ready", o_prf_ready, 0);

        launch(2'd2, 3'd1, 1, 8'h05, 0, 0, 16); wait_done(0); post(1, 16, 0);
        launch(2'd3, 3'd3, 3, 8'hFE, 0, 0, 16); wait_done(1); post(3, 16, 0);
        launch(2'd3, 3'd2, 2, 8'h40, 1, 0, 16); wait_done(0); post(2, 16, 0);
        launch(2'd2, 3'd4, 4, 8'h10, 0, 80, 16); wait_done(0); post(4, 16, 0);
        check("saw_full", saw_full, 1);
        launch(2'd2, 3'd0, 1, 8'h20, 0, 0, 16); wait_done(0); post(1, 16, 0);
        launch(2'd0, 3'd7, 4, 8'h60, 0, 0, 16); wait_done(0); post(4, 16, 0);

        launch(2'd2, 3'd2, 2, 8'h30, 0, 0, 16);
        n = 0;
        while (!(pop_poly == 1 && pop_idx >= 5) && n < 4000) begin @(negedge i_clk); n++; end
        check("rst_reach", n < 4000, 1);
        i_rstn = 0;
        #1;
        check("arst_outs", {o_busy, o_done, o_err, o_prf_req, o_prf_ready, o_cbd_ibytes_valid, o_mem_we, o_cbd_eta}, 0);
        check("arst_data", {o_prf_nonce, o_mem_addr}, 0);
        check("arst_bytes", o_cbd_ibytes, 0);
        repeat (3) @(negedge i_clk);
        i_rstn = 1;
        @(negedge i_clk);
        launch(2'd2, 3'd2, 2, 8'h31, 0, 0, 16); wait_done(0); post(2, 16, 0);

        launch(2'd2, 3'd1, 1, 8'h50, 0, 0, 15); wait_done(0); post(1, 15, ERR_EN);
        repeat (5) @(negedge i_clk);
        check("err_sticky", o_err, ERR_EN);
        launch(2'd2, 3'd1, 1, 8'h51, 0, 0, 16);
        check("err_clear", o_err, 0);
        wait_done(0); post(1, 16, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
